// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_pkg
// Purpose  : Shared MIPS decode encodings and ALU operation/result codes.
// Revision : 1.0 - initial release
// ============================================================================
package id_stage_pipe_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr  = 5'b00000;
    localparam logic        InstValid   = 1'b0;
    localparam logic        InstInValid = 1'b1;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

endpackage
`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_if
// Purpose  : ID/EX register bundle with its valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface id_stage_pipe_if #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
);
    logic                out_valid_o;
    logic                out_ready_i;
    logic [ALUOP_W-1:0]  aluop_o;
    logic [ALUSEL_W-1:0] alusel_o;
    logic [DATA_W-1:0]   reg1_o;
    logic [DATA_W-1:0]   reg2_o;
    logic [REG_AW-1:0]   wd_o;
    logic                wreg_o;
    logic [PC_W-1:0]     pc_o;
    logic                inst_invalid_o;

    modport master (
        output out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o,
               wd_o, wreg_o, pc_o, inst_invalid_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o,
               wd_o, wreg_o, pc_o, inst_invalid_o,
        output out_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : id_fwd_mux
// Purpose  : Source-priority select for one decode operand.
// Revision : 1.0 - initial release
// ============================================================================
module id_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  wire logic              i_read_en,
    input  wire logic [REG_AW-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_rf_data,
    input  wire logic [DATA_W-1:0] i_imm,
    input  wire logic              i_ex_wreg,
    input  wire logic [REG_AW-1:0] i_ex_wd,
    input  wire logic [DATA_W-1:0] i_ex_wdata,
    input  wire logic              i_mem_wreg,
    input  wire logic [REG_AW-1:0] i_mem_wd,
    input  wire logic [DATA_W-1:0] i_mem_wdata,
    output logic      [DATA_W-1:0] o_data
);
    always_comb begin
        o_data = i_rf_data;
        if (!i_read_en) begin
            o_data = i_imm;
        end else if (i_addr == '0) begin
            o_data = '0;
        end else if (FWD_EN && i_ex_wreg && (i_ex_wd == i_addr)) begin
            o_data = i_ex_wdata;
        end else if (FWD_EN && i_mem_wreg && (i_mem_wd == i_addr)) begin
            o_data = i_mem_wdata;
        end
    end
endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : Registered MIPS decode stage with forwarding, load-use stall and flush.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter bit FWD_EN   = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [PC_W-1:0]   pc_i,
    input  wire logic [31:0]       inst_i,
    input  wire logic              in_valid_i,
    output logic                   in_ready_o,
    input  wire logic              flush_i,
    output logic      [REG_AW-1:0] reg1_addr_o,
    output logic      [REG_AW-1:0] reg2_addr_o,
    output logic                   reg1_read_o,
    output logic                   reg2_read_o,
    input  wire logic [DATA_W-1:0] reg1_data_i,
    input  wire logic [DATA_W-1:0] reg2_data_i,
    input  wire logic              ex_wreg_i,
    input  wire logic [REG_AW-1:0] ex_wd_i,
    input  wire logic [DATA_W-1:0] ex_wdata_i,
    input  wire logic              ex_is_load_i,
    input  wire logic              mem_wreg_i,
    input  wire logic [REG_AW-1:0] mem_wd_i,
    input  wire logic [DATA_W-1:0] mem_wdata_i,
    id_stage_pipe_if.master        idex
);
    logic [5:0]          w_op;
    logic [5:0]          w_funct;
    logic [ALUOP_W-1:0]  w_aluop;
    logic [ALUSEL_W-1:0] w_alusel;
    logic                w_wreg;
    logic [REG_AW-1:0]   w_wd;
    logic                w_invalid;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_reg1;
    logic [DATA_W-1:0]   w_reg2;
    logic                w_hazard;
    logic                w_load;
    logic                w_free;

    logic                r_valid;
    logic [ALUOP_W-1:0]  r_aluop;
    logic [ALUSEL_W-1:0] r_alusel;
    logic [DATA_W-1:0]   r_reg1;
    logic [DATA_W-1:0]   r_reg2;
    logic [REG_AW-1:0]   r_wd;
    logic                r_wreg;
    logic [PC_W-1:0]     r_pc;
    logic                r_invalid;

    assign w_op        = inst_i[31:26];
    assign w_funct     = inst_i[5:0];
    assign reg1_addr_o = REG_AW'(inst_i[25:21]);
    assign reg2_addr_o = REG_AW'(inst_i[20:16]);

    always_comb begin
        w_aluop     = ALUOP_W'(EXE_NOP_OP);
        w_alusel    = ALUSEL_W'(EXE_RES_NOP);
        w_wreg      = 1'b0;
        w_wd        = REG_AW'(NOPRegAddr);
        w_invalid   = InstInValid;
        w_imm       = '0;
        reg1_read_o = 1'b0;
        reg2_read_o = 1'b0;
        case (w_op)
            OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                w_wreg      = 1'b1;
                w_wd        = REG_AW'(inst_i[20:16]);
                w_invalid   = InstValid;
                w_alusel    = ALUSEL_W'(EXE_RES_LOGIC);
                reg1_read_o = 1'b1;
                w_imm       = DATA_W'(inst_i[15:0]);
                case (w_op)
                    OP_ANDI: w_aluop = ALUOP_W'(EXE_AND_OP);
                    OP_XORI: w_aluop = ALUOP_W'(EXE_XOR_OP);
                    default: w_aluop = ALUOP_W'(EXE_OR_OP);
                endcase
                // LUI is an OR of rs (normally $0) with the upper-placed immediate.
                if (w_op == OP_LUI) begin
                    w_imm = DATA_W'({inst_i[15:0], 16'h0000});
                end
            end
            OP_SPECIAL: begin
                case (w_funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        w_wreg      = 1'b1;
                        w_wd        = REG_AW'(inst_i[15:11]);
                        w_invalid   = InstValid;
                        w_alusel    = ALUSEL_W'(EXE_RES_LOGIC);
                        reg1_read_o = 1'b1;
                        reg2_read_o = 1'b1;
                        case (w_funct)
                            FN_AND:  w_aluop = ALUOP_W'(EXE_AND_OP);
                            FN_OR:   w_aluop = ALUOP_W'(EXE_OR_OP);
                            FN_XOR:  w_aluop = ALUOP_W'(EXE_XOR_OP);
                            default: w_aluop = ALUOP_W'(EXE_NOR_OP);
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        w_wreg      = 1'b1;
                        w_wd        = REG_AW'(inst_i[15:11]);
                        w_invalid   = InstValid;
                        w_alusel    = ALUSEL_W'(EXE_RES_SHIFT);
                        reg2_read_o = 1'b1;
                        w_imm       = DATA_W'(inst_i[10:6]);
                        case (w_funct)
                            FN_SLL:  w_aluop = ALUOP_W'(EXE_SLL_OP);
                            FN_SRL:  w_aluop = ALUOP_W'(EXE_SRL_OP);
                            default: w_aluop = ALUOP_W'(EXE_SRA_OP);
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd1 (
        .i_read_en (reg1_read_o), .i_addr(reg1_addr_o), .i_rf_data(reg1_data_i), .i_imm(w_imm),
        .i_ex_wreg (ex_wreg_i),   .i_ex_wd(ex_wd_i),    .i_ex_wdata(ex_wdata_i),
        .i_mem_wreg(mem_wreg_i),  .i_mem_wd(mem_wd_i),  .i_mem_wdata(mem_wdata_i),
        .o_data    (w_reg1)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd2 (
        .i_read_en (reg2_read_o), .i_addr(reg2_addr_o), .i_rf_data(reg2_data_i), .i_imm(w_imm),
        .i_ex_wreg (ex_wreg_i),   .i_ex_wd(ex_wd_i),    .i_ex_wdata(ex_wdata_i),
        .i_mem_wreg(mem_wreg_i),  .i_mem_wd(mem_wd_i),  .i_mem_wdata(mem_wdata_i),
        .o_data    (w_reg2)
    );

    // A load result is not available until it leaves EX, so forwarding cannot cover it.
    assign w_hazard = ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                      ((reg1_read_o && (ex_wd_i == reg1_addr_o)) ||
                       (reg2_read_o && (ex_wd_i == reg2_addr_o)));

    assign w_free     = !r_valid || idex.out_ready_i;
    assign in_ready_o = w_free && !w_hazard && !flush_i;
    assign w_load     = in_valid_i && in_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_aluop   <= ALUOP_W'(EXE_NOP_OP);
            r_alusel  <= ALUSEL_W'(EXE_RES_NOP);
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_wd      <= '0;
            r_wreg    <= 1'b0;
            r_pc      <= '0;
            r_invalid <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_wreg  <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_aluop   <= w_aluop;
            r_alusel  <= w_alusel;
            r_reg1    <= w_reg1;
            r_reg2    <= w_reg2;
            r_wd      <= w_wd;
            r_wreg    <= w_wreg;
            r_pc      <= pc_i;
            r_invalid <= w_invalid;
        end else if (w_free) begin
            r_valid <= 1'b0;
            r_wreg  <= 1'b0;
        end
    end

    assign idex.out_valid_o    = r_valid;
    assign idex.aluop_o        = r_aluop;
    assign idex.alusel_o       = r_alusel;
    assign idex.reg1_o         = r_reg1;
    assign idex.reg2_o         = r_reg2;
    assign idex.wd_o           = r_wd;
    assign idex.wreg_o         = r_wreg;
    assign idex.pc_o           = r_pc;
    assign idex.inst_invalid_o = r_invalid;
endmodule
`default_nettype wire
